// File: rtl/apb_slv_pkg.sv
// Shared types and constants for the APB register-file completer.
// FSM encoding, offset/data widths and the control-word register index.
package apb_slv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int OFFSET_W = 10;
  localparam int DATA_W   = 32;
  localparam int CTRL_IDX = 0;

endpackage

// File: rtl/apb_wait_counter.sv
// 4-bit load/decrement wait-state counter with zero flag.
// Only built when APB_SLV_WAIT_EN is defined.
`ifdef APB_SLV_WAIT_EN
module apb_wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == 4'd0);

endmodule
`endif

// File: rtl/apb_slave_regfile.sv
// APB completer with a bank of 32-bit registers; reg 0 exported as CTRL_REG.
// APB_SLV_WAIT_EN selects the registered wait-state FSM, else zero-wait.
module apb_slave_regfile
  import apb_slv_pkg::*;
#(
  parameter int NUM_REGS    = 16,
  parameter int SEL_IDX     = 0,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [2:0]        PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PADDR,
  input  logic [31:0]       PWDATA,
  output logic              PREADY,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PSLVERR,
  output logic [DATA_W-1:0] CTRL_REG
);

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [IW-1:0] CI = IW'(CTRL_IDX);

  logic                sel;
  logic [OFFSET_W-1:0] idx;
  logic                err;
  logic                we;
  logic [IW-1:0]       widx;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W-1:0]   regs [NUM_REGS];

  // upper address bits are decoded by the bridge
  logic unused_addr;
  assign unused_addr = ^PADDR[31:12];

  assign sel = PSEL[SEL_IDX];
  assign idx = PADDR[11:2];
  assign err = (PADDR[1:0] != 2'b00) || (int'(idx) >= NUM_REGS);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[widx] <= wdata;
    end
  end

  assign CTRL_REG = regs[CI];

`ifdef APB_SLV_WAIT_EN

  state_t            state;
  state_t            nstate;
  logic              setup;
  logic              cnt_zero;
  logic              cnt_load;
  logic              cnt_dec;
  logic              fire;
  logic [IW-1:0]     l_idx;
  logic              l_err;
  logic              l_wr;
  logic [DATA_W-1:0] l_data;

  assign setup = sel && !PENABLE;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: if (setup) nstate = WAIT;
      WAIT: begin
        if (!sel) begin
          nstate = IDLE;
        end else if (PENABLE && cnt_zero) begin
          nstate = RESP;
        end
      end
      RESP:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    cnt_load = (state == IDLE) && setup;
    fire     = (state == WAIT) && sel && PENABLE && cnt_zero;
    cnt_dec  = (state == WAIT) && sel && PENABLE && !cnt_zero;
  end

  apb_wait_counter u_cnt (
    .clk      (HCLK),
    .rst      (HRESET),
    .load     (cnt_load),
    .load_val (4'(WAIT_CYCLES)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
      l_idx   <= '0;
      l_err   <= 1'b0;
      l_wr    <= 1'b0;
      l_data  <= '0;
    end else begin
      if (cnt_load) begin
        l_idx  <= idx[IW-1:0];
        l_err  <= err;
        l_wr   <= PWRITE;
        l_data <= PWDATA;
      end
      if (fire) begin
        PREADY  <= 1'b1;
        PSLVERR <= l_err;
        if (l_err) begin
          PRDATA <= '0;
        end else if (!l_wr) begin
          PRDATA <= regs[l_idx];
        end
      end else if (state == RESP) begin
        PREADY  <= 1'b0;
        PSLVERR <= 1'b0;
      end
    end
  end

  assign we    = fire && l_wr && !l_err;
  assign widx  = l_idx;
  assign wdata = l_data;

`else

  assign PREADY  = sel & PENABLE;
  assign PSLVERR = sel & PENABLE & err;
  assign PRDATA  = err ? '0 : regs[idx[IW-1:0]];

  assign we    = sel & PENABLE & PWRITE & !err;
  assign widx  = idx[IW-1:0];
  assign wdata = PWDATA;

`endif

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench for apb_slave_regfile (scoreboard of expected responses).
// Latency and wait-state scenarios follow APB_SLV_WAIT_EN.
module tb_apb_slave_regfile;

  localparam int NREGS = 16;
  localparam int WAITC = 2;
`ifdef APB_SLV_WAIT_EN
  localparam int LAT = WAITC + 1;
`else
  localparam int LAT = 0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [2:0]  PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;
  logic [31:0] CTRL_REG;

  typedef struct {
    bit          wr;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mdl [NREGS];
  int          checks   = 0;
  int          failures = 0;

  apb_slave_regfile #(
    .NUM_REGS    (NREGS),
    .SEL_IDX     (0),
    .WAIT_CYCLES (WAITC)
  ) dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PREADY   (PREADY),
    .PRDATA   (PRDATA),
    .PSLVERR  (PSLVERR),
    .CTRL_REG (CTRL_REG)
  );

  always #5 HCLK = ~HCLK;

  task automatic xfer(input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input bit idle_after);
    exp_t e;
    exp_t g;
    int   n;
    int   i;
    bit   to;
    i       = int'(addr[11:2]);
    e.wr    = wr;
    e.err   = (addr[1:0] != 2'b00) || (i >= NREGS);
    e.rdata = e.err ? 32'h0 : mdl[i];
    if (wr && !e.err) mdl[i] = data;
    sbq.push_back(e);
    PSEL    = 3'b001;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = addr;
    PWDATA  = data;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    n  = 0;
    to = 1'b0;
    forever begin
      @(negedge HCLK);
      if (PREADY) break;
      n++;
      if (n > 40) begin
        to = 1'b1;
        break;
      end
    end
    g = sbq.pop_front();
    checks++;
    if (to) begin
      failures++;
      $display("FAIL xfer_timeout addr=%h got PREADY=0 required PREADY=1", addr);
    end else begin
      checks++;
      if (n !== LAT) begin
        failures++;
        $display("FAIL latency addr=%h got %0d required %0d", addr, n, LAT);
      end
      checks++;
      if (PSLVERR !== g.err) begin
        failures++;
        $display("FAIL pslverr addr=%h got %b required %b", addr, PSLVERR, g.err);
      end
      if (!g.wr || g.err) begin
        checks++;
        if (PRDATA !== g.rdata) begin
          failures++;
          $display("FAIL prdata addr=%h got %h required %h", addr, PRDATA, g.rdata);
        end
      end
`ifdef APB_SLV_WAIT_EN
      checks++;
      if (CTRL_REG !== mdl[0]) begin
        failures++;
        $display("FAIL ctrl_resp addr=%h got %h required %h", addr, CTRL_REG, mdl[0]);
      end
`endif
    end
    @(posedge HCLK); #1;
`ifndef APB_SLV_WAIT_EN
    checks++;
    if (CTRL_REG !== mdl[0]) begin
      failures++;
      $display("FAIL ctrl_after addr=%h got %h required %h", addr, CTRL_REG, mdl[0]);
    end
`endif
    PENABLE = 1'b0;
    if (idle_after) begin
      PSEL = 3'b000;
`ifdef APB_SLV_WAIT_EN
      @(negedge HCLK);
      checks++;
      if (PREADY !== 1'b0 || PSLVERR !== 1'b0) begin
        failures++;
        $display("FAIL ready_one_cycle got %b%b required 00", PREADY, PSLVERR);
      end
      @(posedge HCLK); #1;
`endif
    end
  endtask

  task automatic test_reset();
    HRESET  = 1'b1;
    PSEL    = 3'b000;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = 32'h0;
    PWDATA  = 32'h0;
    for (int i = 0; i < NREGS; i++) mdl[i] = 32'h0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    checks += 4;
    if (PREADY !== 1'b0) begin
      failures++;
      $display("FAIL rst_pready got %b required 0", PREADY);
    end
    if (PSLVERR !== 1'b0) begin
      failures++;
      $display("FAIL rst_pslverr got %b required 0", PSLVERR);
    end
    if (PRDATA !== 32'h0) begin
      failures++;
      $display("FAIL rst_prdata got %h required 0", PRDATA);
    end
    if (CTRL_REG !== 32'h0) begin
      failures++;
      $display("FAIL rst_ctrl got %h required 0", CTRL_REG);
    end
    @(posedge HCLK); #1;
    HRESET = 1'b0;
  endtask

  task automatic test_basic();
    xfer(1'b0, 32'h00, 32'h0, 1'b1);
    xfer(1'b1, 32'h04, 32'hDEADBEEF, 1'b0);
    xfer(1'b0, 32'h04, 32'h0, 1'b0);
    xfer(1'b1, 32'h00, 32'h12345678, 1'b0);
    xfer(1'b0, 32'h00, 32'h0, 1'b1);
    xfer(1'b1, 32'h3C, 32'hCAFEF00D, 1'b0);
    xfer(1'b0, 32'h3C, 32'h0, 1'b1);
  endtask

  task automatic test_errors();
    xfer(1'b0, 32'h40, 32'h0, 1'b0);
    xfer(1'b1, 32'h02, 32'h55555555, 1'b0);
    xfer(1'b1, 32'hFFC, 32'h66666666, 1'b0);
    xfer(1'b0, 32'h00, 32'h0, 1'b0);
    xfer(1'b0, 32'h04, 32'h0, 1'b1);
  endtask

  task automatic test_other_sel();
    bit seen;
    seen    = 1'b0;
    PSEL    = 3'b110;
    PENABLE = 1'b0;
    PWRITE  = 1'b1;
    PADDR   = 32'h04;
    PWDATA  = 32'h0BAD0BAD;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    repeat (4) begin
      @(negedge HCLK);
      if (PREADY) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL other_sel got PREADY=1 required 0");
    end
    @(posedge HCLK); #1;
    PSEL    = 3'b000;
    PENABLE = 1'b0;
    xfer(1'b0, 32'h04, 32'h0, 1'b1);
  endtask

`ifdef APB_SLV_WAIT_EN
  task automatic test_abort();
    bit seen;
    seen    = 1'b0;
    PSEL    = 3'b001;
    PENABLE = 1'b0;
    PWRITE  = 1'b1;
    PADDR   = 32'h10;
    PWDATA  = 32'h11112222;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    @(posedge HCLK); #1;
    PSEL    = 3'b000;
    PENABLE = 1'b0;
    repeat (5) begin
      @(negedge HCLK);
      if (PREADY) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL abort_pready got PREADY=1 required 0");
    end
    @(posedge HCLK); #1;
    xfer(1'b0, 32'h10, 32'h0, 1'b0);
    xfer(1'b1, 32'h10, 32'h33334444, 1'b0);
    xfer(1'b0, 32'h10, 32'h0, 1'b1);
  endtask

  task automatic test_penable_idle();
    bit seen;
    seen    = 1'b0;
    PSEL    = 3'b001;
    PENABLE = 1'b1;
    PWRITE  = 1'b1;
    PADDR   = 32'h14;
    PWDATA  = 32'h77777777;
    repeat (5) begin
      @(negedge HCLK);
      if (PREADY) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL penable_idle got PREADY=1 required 0");
    end
    @(posedge HCLK); #1;
    PSEL    = 3'b000;
    PENABLE = 1'b0;
    @(posedge HCLK); #1;
    xfer(1'b0, 32'h14, 32'h0, 1'b1);
  endtask
`endif

  task automatic test_reset_mid();
    PSEL    = 3'b001;
    PENABLE = 1'b0;
    PWRITE  = 1'b1;
    PADDR   = 32'h08;
    PWDATA  = 32'hA5A5A5A5;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    HRESET  = 1'b1;
    @(posedge HCLK); #1;
    HRESET  = 1'b0;
    PSEL    = 3'b000;
    PENABLE = 1'b0;
    for (int i = 0; i < NREGS; i++) mdl[i] = 32'h0;
    @(negedge HCLK);
    checks += 2;
    if (PREADY !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_pready got %b required 0", PREADY);
    end
    if (CTRL_REG !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_ctrl got %h required 0", CTRL_REG);
    end
    @(posedge HCLK); #1;
    xfer(1'b0, 32'h08, 32'h0, 1'b0);
    xfer(1'b0, 32'h04, 32'h0, 1'b1);
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int k = 0; k < 24; k++) begin
      a = 32'($urandom_range(0, 19)) << 2;
      if ($urandom_range(0, 7) == 0) a[0] = 1'b1;
      a[31:12] = 20'($urandom);
      xfer(1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)));
    end
    PSEL    = 3'b000;
    PENABLE = 1'b0;
    for (int k = 0; k < NREGS; k++) begin
      xfer(1'b0, 32'(k) << 2, 32'h0, 1'b0);
    end
    PSEL = 3'b000;
  endtask

  initial begin
    test_reset();
    @(posedge HCLK); #1;
    test_basic();
    test_errors();
    test_other_sel();
`ifdef APB_SLV_WAIT_EN
    test_abort();
    test_penable_idle();
`endif
    test_reset_mid();
    test_random();
    repeat (2) @(posedge HCLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
